food_place_ctrl: RTL and testbench

//  Sequences random_box to place a new food cell on the snake grid. Seeds the

---
 rtl/food_place_ctrl_pkg.sv | 23 ++
 rtl/food_place_ctrl_if.sv | 36 +++
 rtl/food_place_ctrl.sv | 160 ++++++++++++++++
 tb/tb_food_place_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/food_place_ctrl_pkg.sv
// Shared constants and FSM state type for the food placement controller.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package food_place_ctrl_pkg;

    localparam int DEF_COORD_W   = 10;  // matches random_box coordinate width
    localparam int DEF_GRID_W    = 32;  // valid x = 0..DEF_GRID_W-1
    localparam int DEF_GRID_H    = 24;  // valid y = 0..DEF_GRID_H-1
    localparam int DEF_DRIVE_LAT = 1;   // drive pulse to stable box coordinates
    localparam int DEF_MAX_TRY   = 16;  // rejected candidates before giving up

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_DRIVE,
        S_WAIT,
        S_RANGE,
        S_CHECK,
        S_HOLD,
        S_FAIL
    } state_t;

endpackage

// File: rtl/food_place_ctrl_if.sv
// Bundle of game-FSM, random_box, body-store and food-output signals of the
// food placement controller. master = controller side, slave = environment.
// Ports: start/eaten (game FSM), load/drive/box_x/box_y (random_box),
//        chk_req/chk_x/chk_y/chk_done/chk_hit (body store), food_x/food_y/food_vld/fail.
interface food_place_ctrl_if
    import food_place_ctrl_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W
);
    logic               start;
    logic               eaten;
    logic               load;
    logic               drive;
    logic [COORD_W-1:0] box_x;
    logic [COORD_W-1:0] box_y;
    logic               chk_req;
    logic [COORD_W-1:0] chk_x;
    logic [COORD_W-1:0] chk_y;
    logic               chk_done;
    logic               chk_hit;
    logic [COORD_W-1:0] food_x;
    logic [COORD_W-1:0] food_y;
    logic               food_vld;
    logic               fail;

    modport master (
        input  start, eaten, box_x, box_y, chk_done, chk_hit,
        output load, drive, chk_req, chk_x, chk_y, food_x, food_y, food_vld, fail
    );

    modport slave (
        output start, eaten, box_x, box_y, chk_done, chk_hit,
        input  load, drive, chk_req, chk_x, chk_y, food_x, food_y, food_vld, fail
    );

endinterface

// File: rtl/food_place_ctrl.sv
// Places food: seeds/pulses random_box, rejects off-grid or on-body candidates, publishes the cell.
// Latency: food_vld rises 5 cycles after start is sampled on the ideal path (DRIVE_LAT=1, same-cycle chk_done).
// Backpressure: one outstanding body query, chk_req/chk_x/chk_y held until chk_done; start restarts from any state.
// Ports: clk, rst (async, active-high), bus (food_place_ctrl_if.master).
module food_place_ctrl
    import food_place_ctrl_pkg::*;
#(
    parameter int COORD_W   = DEF_COORD_W,
    parameter int GRID_W    = DEF_GRID_W,
    parameter int GRID_H    = DEF_GRID_H,
    parameter int DRIVE_LAT = DEF_DRIVE_LAT,
    parameter int MAX_TRY   = DEF_MAX_TRY
)(
    input  logic                      clk,
    input  logic                      rst,
    food_place_ctrl_if.master         bus
);

    localparam int TRY_W  = $clog2(MAX_TRY) + 1;
    localparam int WAIT_W = (DRIVE_LAT > 1) ? $clog2(DRIVE_LAT) : 1;

    state_t             state;
    logic [TRY_W-1:0]   try_cnt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [COORD_W-1:0] cand_x;
    logic [COORD_W-1:0] cand_y;

    logic               load_r;
    logic               drive_r;
    logic               chk_req_r;
    logic [COORD_W-1:0] chk_x_r;
    logic [COORD_W-1:0] chk_y_r;
    logic [COORD_W-1:0] food_x_r;
    logic [COORD_W-1:0] food_y_r;
    logic               food_vld_r;
    logic               fail_r;

    logic cand_in_grid;
    logic last_try;
    logic reject;

    assign cand_in_grid = (cand_x < COORD_W'(GRID_W)) && (cand_y < COORD_W'(GRID_H));
    assign last_try     = (try_cnt == TRY_W'(MAX_TRY - 1));

    // A candidate is thrown away either for being off-grid or for landing on the body.
    always_comb begin
        reject = 1'b0;
        if (state == S_RANGE && !cand_in_grid)
            reject = 1'b1;
        if (state == S_CHECK && bus.chk_done && bus.chk_hit)
            reject = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            try_cnt    <= '0;
            wait_cnt   <= '0;
            cand_x     <= '0;
            cand_y     <= '0;
            load_r     <= 1'b0;
            drive_r    <= 1'b0;
            chk_req_r  <= 1'b0;
            chk_x_r    <= '0;
            chk_y_r    <= '0;
            food_x_r   <= '0;
            food_y_r   <= '0;
            food_vld_r <= 1'b0;
            fail_r     <= 1'b0;
        end else begin
            // load/drive are single-cycle pulses tied to the SEED/DRIVE states.
            load_r  <= 1'b0;
            drive_r <= 1'b0;

            if (bus.start) begin
                // Start overrides everything, including a pending query and a same-cycle eaten.
                state      <= S_SEED;
                load_r     <= 1'b1;
                chk_req_r  <= 1'b0;
                food_vld_r <= 1'b0;
                fail_r     <= 1'b0;
                try_cnt    <= '0;
            end else begin
                case (state)
                    S_IDLE: ;
                    S_SEED: begin
                        try_cnt <= '0;
                        drive_r <= 1'b1;
                        state   <= S_DRIVE;
                    end
                    S_DRIVE: begin
                        wait_cnt <= '0;
                        state    <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (wait_cnt == WAIT_W'(DRIVE_LAT - 1)) begin
                            cand_x <= bus.box_x;
                            cand_y <= bus.box_y;
                            state  <= S_RANGE;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    S_RANGE: begin
                        if (cand_in_grid) begin
                            chk_req_r <= 1'b1;
                            chk_x_r   <= cand_x;
                            chk_y_r   <= cand_y;
                            state     <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        if (bus.chk_done) begin
                            chk_req_r <= 1'b0;
                            if (!bus.chk_hit) begin
                                food_x_r   <= cand_x;
                                food_y_r   <= cand_y;
                                food_vld_r <= 1'b1;
                                state      <= S_HOLD;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (bus.eaten) begin
                            food_vld_r <= 1'b0;
                            try_cnt    <= '0;
                            drive_r    <= 1'b1;
                            state      <= S_DRIVE;
                        end
                    end
                    S_FAIL: ;
                    default: state <= S_IDLE;
                endcase

                if (reject) begin
                    if (last_try) begin
                        state      <= S_FAIL;
                        fail_r     <= 1'b1;
                        food_vld_r <= 1'b0;
                    end else begin
                        try_cnt <= try_cnt + 1'b1;
                        drive_r <= 1'b1;
                        state   <= S_DRIVE;
                    end
                end
            end
        end
    end

    assign bus.load     = load_r;
    assign bus.drive    = drive_r;
    assign bus.chk_req  = chk_req_r;
    assign bus.chk_x    = chk_x_r;
    assign bus.chk_y    = chk_y_r;
    assign bus.food_x   = food_x_r;
    assign bus.food_y   = food_y_r;
    assign bus.food_vld = food_vld_r;
    assign bus.fail     = fail_r;

endmodule

// File: tb/tb_food_place_ctrl.sv
// Bench for food_place_ctrl: scripted random_box and body store, placement model, event scoreboard.
// Latency: n/a.
// Backpressure: body store answers each query after a configurable delay.
module tb_food_place_ctrl;
    import food_place_ctrl_pkg::*;

    localparam int CW = DEF_COORD_W;
    typedef logic [CW-1:0] coord_t;

    typedef struct {
        bit     is_fail;
        coord_t x;
        coord_t y;
        int     drives;
        int     loads;
        int     queries;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    food_place_ctrl_if #(.COORD_W(CW)) bus();

    food_place_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    coord_t box_xq[$];
    coord_t box_yq[$];
    bit     hit_q[$];
    coord_t dx[$];
    coord_t dy[$];
    bit     dh[$];
    exp_t   exp_q[$];
    int     chk_delay = 0;
    int     hit_pct   = 50;

    int n_drive = 0, n_load = 0, n_query = 0, overlap_cnt = 0;
    int food_rise_cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // random_box stand-in: the coordinate for a drive pulse appears DRIVE_LAT cycles later.
    initial begin
        bus.box_x = '0;
        bus.box_y = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.drive) begin
                @(posedge clk); #1;
                if (box_xq.size() > 0) begin
                    bus.box_x = box_xq.pop_front();
                    bus.box_y = box_yq.pop_front();
                end
            end
        end
    end

    // Body store stand-in: answers each query after chk_delay cycles from the scripted hit list.
    initial begin
        bit     busy;
        int     cnt;
        coord_t qx, qy;
        busy = 0; cnt = 0; qx = '0; qy = '0;
        bus.chk_done = 1'b0;
        bus.chk_hit  = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.chk_done = 1'b0;
            bus.chk_hit  = 1'b0;
            if (bus.chk_req && !busy) begin
                busy = 1;
                cnt  = chk_delay;
                qx   = bus.chk_x;
                qy   = bus.chk_y;
                n_query++;
                check("query_in_grid", (qx < DEF_GRID_W) && (qy < DEF_GRID_H), 1);
            end
            if (busy) begin
                if (cnt == 0) begin
                    if (bus.chk_req) begin
                        check("chk_x_stable", bus.chk_x, qx);
                        check("chk_y_stable", bus.chk_y, qy);
                    end
                    bus.chk_done = 1'b1;
                    bus.chk_hit  = (hit_q.size() > 0) ? hit_q.pop_front() : 1'b0;
                    busy = 0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Monitor: every rising food_vld / fail is matched against the next expected outcome.
    initial begin
        bit   fv_prev, fl_prev;
        exp_t e;
        fv_prev = 0; fl_prev = 0;
        forever begin
            @(posedge clk); #1;
            if (bus.drive) n_drive++;
            if (bus.load) n_load++;
            if (bus.load && bus.drive) overlap_cnt++;
            if ((bus.food_vld && !fv_prev) || (bus.fail && !fl_prev)) begin
                if (bus.food_vld && !fv_prev) food_rise_cyc = cyc;
                check("event_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("outcome_fail", bus.fail, e.is_fail);
                    if (e.is_fail) begin
                        check("fail_food_vld", bus.food_vld, 0);
                    end else begin
                        check("food_x", bus.food_x, e.x);
                        check("food_y", bus.food_y, e.y);
                    end
                    check("drive_pulses", n_drive, e.drives);
                    check("load_pulses", n_load, e.loads);
                    check("body_queries", n_query, e.queries);
                end
                n_drive = 0; n_load = 0; n_query = 0;
            end
            fv_prev = bus.food_vld;
            fl_prev = bus.fail;
        end
    end

    task automatic add(input int x, input int y, input bit h);
        dx.push_back(coord_t'(x));
        dy.push_back(coord_t'(y));
        dh.push_back(h);
    endtask

    // Reference model: walk candidates in order; off-grid ones cost a try but no query,
    // on-grid ones consume one body answer; first free cell wins, MAX_TRY rejections fail.
    task automatic plan(input bit reseed, input bit rnd, output bit failed);
        exp_t   e;
        int     tries;
        coord_t x, y;
        bit     h, inr;
        e.is_fail = 0; e.x = '0; e.y = '0; e.drives = 0; e.loads = reseed ? 1 : 0; e.queries = 0;
        tries = 0;
        forever begin
            if (rnd) begin
                x = coord_t'($urandom_range(0, 40));
                y = coord_t'($urandom_range(0, 30));
                h = ($urandom_range(0, 99) < hit_pct);
            end else begin
                if (dx.size() == 0) break;
                x = dx.pop_front();
                y = dy.pop_front();
                h = dh.pop_front();
            end
            box_xq.push_back(x);
            box_yq.push_back(y);
            e.drives++;
            inr = (x < DEF_GRID_W) && (y < DEF_GRID_H);
            if (inr) begin
                hit_q.push_back(h);
                e.queries++;
                if (!h) begin
                    e.x = x;
                    e.y = y;
                    break;
                end
            end
            tries++;
            if (tries == DEF_MAX_TRY) begin
                e.is_fail = 1;
                break;
            end
        end
        dx.delete(); dy.delete(); dh.delete();
        failed = e.is_fail;
        exp_q.push_back(e);
    endtask

    task automatic trig(input bit s, input bit e, output int c);
        @(posedge clk); #1;
        bus.start = s;
        bus.eaten = e;
        c = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.eaten = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            check("event_timeout_pending", exp_q.size(), 0);
            exp_q.delete();
        end
        @(posedge clk); #2;
    endtask

    initial begin
        #400000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int c, n;
        bit f, last_fail, rs;

        rst = 1'b1;
        bus.start = 1'b0;
        bus.eaten = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_load", bus.load, 0);
        check("rst_drive", bus.drive, 0);
        check("rst_chk_req", bus.chk_req, 0);
        check("rst_food_vld", bus.food_vld, 0);
        check("rst_fail", bus.fail, 0);
        check("rst_food_x", bus.food_x, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // 1: single in-grid free cell; start is sampled on the edge after c, food 5 edges later.
        add(5, 7, 0);
        plan(1, 0, f);
        trig(1, 0, c);
        wait_done(50);
        check("start_to_food_latency", food_rise_cyc - c, 6);

        // 2: two off-grid candidates before a free cell.
        add(40, 3, 0); add(3, 30, 0); add(9, 9, 0);
        plan(0, 0, f);
        trig(0, 1, c);
        wait_done(80);

        // 3: body hit then miss, answers delayed 3 cycles.
        chk_delay = 3;
        add(4, 4, 1); add(6, 2, 0);
        plan(0, 0, f);
        trig(0, 1, c);
        wait_done(80);
        chk_delay = 0;

        // 4: every candidate on the body -> failure; eaten ignored; start recovers.
        for (int i = 0; i < DEF_MAX_TRY; i++) add(i, i, 1);
        plan(0, 0, f);
        trig(0, 1, c);
        wait_done(300);
        trig(0, 1, c);
        repeat (5) @(posedge clk);
        #1;
        check("fail_held_after_eaten", bus.fail, 1);
        check("no_food_after_eaten", bus.food_vld, 0);
        check("no_drive_in_fail", n_drive, 0);
        add(2, 3, 0);
        plan(1, 0, f);
        trig(1, 0, c);
        wait_done(80);

        // 5: eaten drops food_vld next cycle without reseed; start+eaten together reseeds.
        add(1, 1, 0);
        plan(0, 0, f);
        trig(0, 1, c);
        check("food_vld_low_after_eaten", bus.food_vld, 0);
        check("no_load_on_eaten", bus.load, 0);
        wait_done(80);
        add(7, 8, 0);
        plan(1, 0, f);
        trig(1, 1, c);
        wait_done(80);

        // Randomized placements.
        last_fail = 0;
        for (int k = 0; k < 25; k++) begin
            chk_delay = $urandom_range(0, 3);
            hit_pct   = ($urandom_range(0, 1) == 1) ? 95 : 40;
            rs        = last_fail || ($urandom_range(0, 3) == 0);
            plan(rs, 1, f);
            trig(rs, !rs, c);
            wait_done(400);
            last_fail = f;
        end

        // 6: reset in the middle of a query; its late answer must not wake the FSM.
        chk_delay = 6;
        box_xq.push_back(coord_t'(3));
        box_yq.push_back(coord_t'(3));
        hit_q.push_back(1'b0);
        trig(1, 0, c);
        n = 0;
        while (!bus.chk_req && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check("chk_req_seen_before_reset", bus.chk_req, 1);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_chk_req", bus.chk_req, 0);
        check("async_rst_food_vld", bus.food_vld, 0);
        check("async_rst_fail", bus.fail, 0);
        check("async_rst_load", bus.load, 0);
        check("async_rst_drive", bus.drive, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        n_drive = 0; n_load = 0; n_query = 0;
        repeat (10) @(posedge clk);
        #2;
        check("idle_after_late_done_drive", n_drive, 0);
        check("idle_after_late_done_load", n_load, 0);
        check("idle_after_late_done_req", bus.chk_req, 0);
        check("idle_after_late_done_food", bus.food_vld, 0);
        n_query = 0;

        chk_delay = 0;
        add(5, 5, 0);
        plan(1, 0, f);
        trig(1, 0, c);
        wait_done(80);

        check("load_drive_overlap", overlap_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
